cdb_arbiter: RTL

Arbiter that shares the single common data bus (CDB) between the ALU reservation station and the load/store buffer. Each producer has a valid/ready handshake into its own one-entry holding slot. Every cycle, one pending result is granted in round-robin order and broadcast on a registered CDB output. RS entries snoop that output, and ROB writeback reads it. On misprediction, the arbiter flushes all in-flight results.

---
 rtl/cdb_pkg.sv | 29 ++
 rtl/cdb_hold_slot.sv | 35 +++
 rtl/cdb_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// Shared widths, source encoding and payload layouts for the CDB arbiter.
package cdb_pkg;

    localparam int DATA_W  = 32;
    localparam int TAG_W   = 5;
    localparam int RSNUM_W = 3;

    // Tag value meaning "no destination register"; still broadcast so the RS can free its entry.
    localparam logic [TAG_W-1:0] TAG_FREE = '0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LS  = 1'b1
    } cdb_src_e;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [DATA_W-1:0]  data;
        logic [RSNUM_W-1:0] rsnum;
        logic [DATA_W-1:0]  offset;
        logic               pc_valid;
    } alu_result_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } ls_result_t;

endpackage

// File: rtl/cdb_hold_slot.sv
// One-entry holding register: fills on accept, empties on grant, clear wins over both.
module cdb_hold_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         accept,
    input  logic         grant,
    input  logic [W-1:0] load_data,
    output logic         valid,
    output logic [W-1:0] data
);

    // Occupancy: a refill in the same edge as the grant keeps the slot full.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
        end else if (accept) begin
            valid <= 1'b1;
        end else if (grant) begin
            valid <= 1'b0;
        end
    end

    // Payload capture on accept only.
    // NOTE: the payload is not reset; it is qualified by valid and never observed while empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            data <= load_data;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus between the ALU RS and the load/store buffer.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_W  = cdb_pkg::DATA_W,
    parameter int TAG_W   = cdb_pkg::TAG_W,
    parameter int RSNUM_W = cdb_pkg::RSNUM_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,

    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [TAG_W-1:0]   alu_tag,
    input  logic [DATA_W-1:0]  alu_data,
    input  logic [RSNUM_W-1:0] alu_rsnum,
    input  logic [DATA_W-1:0]  alu_offset,
    input  logic               alu_pc_valid,

    input  logic               ls_valid,
    output logic               ls_ready,
    input  logic [TAG_W-1:0]   ls_tag,
    input  logic [DATA_W-1:0]  ls_data,

    output logic               cdb_valid,
    output logic               cdb_src,
    output logic [TAG_W-1:0]   cdb_tag,
    output logic [DATA_W-1:0]  cdb_data,
    output logic [RSNUM_W-1:0] cdb_rsnum,
    output logic [DATA_W-1:0]  cdb_offset,
    output logic               cdb_pc_valid
);

    alu_result_t alu_in, alu_q;
    ls_result_t  ls_in, ls_q;
    logic        alu_full, ls_full;
    logic        grant_alu, grant_ls;
    logic        accept_alu, accept_ls;
    cdb_src_e    prio;

    // Field order of the concatenations follows the packed struct layouts.
    assign alu_in = {alu_tag, alu_data, alu_rsnum, alu_offset, alu_pc_valid};
    assign ls_in  = {ls_tag, ls_data};

    // Grant and ready depend only on registered state, so ready has no path from any input.
    assign grant_alu = alu_full && (!ls_full  || prio == SRC_ALU);
    assign grant_ls  = ls_full  && (!alu_full || prio == SRC_LS);
    assign alu_ready = !alu_full || grant_alu;
    assign ls_ready  = !ls_full  || grant_ls;

    // Anything offered during a flush cycle is dropped even if ready is high.
    assign accept_alu = alu_valid && alu_ready && !flush;
    assign accept_ls  = ls_valid  && ls_ready  && !flush;

    cdb_hold_slot #(.W($bits(alu_result_t))) u_alu_slot (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .accept    (accept_alu),
        .grant     (grant_alu),
        .load_data (alu_in),
        .valid     (alu_full),
        .data      (alu_q)
    );

    cdb_hold_slot #(.W($bits(ls_result_t))) u_ls_slot (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .accept    (accept_ls),
        .grant     (grant_ls),
        .load_data (ls_in),
        .valid     (ls_full),
        .data      (ls_q)
    );

    // Round-robin pointer: after any grant, favour the source that lost.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            prio <= SRC_ALU;
        end else if (grant_alu) begin
            prio <= SRC_LS;
        end else if (grant_ls) begin
            prio <= SRC_ALU;
        end
    end

    // CDB output registers: one beat per grant, all-zero when idle, flushed or in reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cdb_valid    <= 1'b0;
            cdb_src      <= SRC_ALU;
            cdb_tag      <= '0;
            cdb_data     <= '0;
            cdb_rsnum    <= '0;
            cdb_offset   <= '0;
            cdb_pc_valid <= 1'b0;
        end else if (grant_alu) begin
            cdb_valid    <= 1'b1;
            cdb_src      <= SRC_ALU;
            cdb_tag      <= alu_q.tag;
            cdb_data     <= alu_q.data;
            cdb_rsnum    <= alu_q.rsnum;
            cdb_offset   <= alu_q.offset;
            cdb_pc_valid <= alu_q.pc_valid;
        end else if (grant_ls) begin
            cdb_valid    <= 1'b1;
            cdb_src      <= SRC_LS;
            cdb_tag      <= ls_q.tag;
            cdb_data     <= ls_q.data;
            cdb_rsnum    <= '0;
            cdb_offset   <= '0;
            cdb_pc_valid <= 1'b0;
        end else begin
            cdb_valid    <= 1'b0;
            cdb_src      <= SRC_ALU;
            cdb_tag      <= '0;
            cdb_data     <= '0;
            cdb_rsnum    <= '0;
            cdb_offset   <= '0;
            cdb_pc_valid <= 1'b0;
        end
    end

endmodule
